// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift/rotate unit shifting STEP bits per clock with a done pulse.
// Optional registered result-is-zero flag enabled by defining SEQ_SHIFT_ZERO_FLAG_EN.
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [SHW-1:0] rem, rem_nx, k;
  logic [1:0] mode_q;
  logic [WIDTH-1:0] y_nx, sra, shifted;
  // STEP may equal WIDTH; its truncated form is then never selected since rem < WIDTH
  always_comb k = (int'(rem) < STEP) ? rem : SHW'(STEP);
  assign sra = $signed(y) >>> k;
  always_comb begin
    shifted = mode_q == 2'b00 ? y << k :
              mode_q == 2'b01 ? y >> k :
              mode_q == 2'b10 ? sra :
              (y >> k) | (y << (WIDTH - int'(k)));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem    <= '0;
      mode_q <= '0;
      y      <= '0;
    end else begin
      rem <= rem_nx;
      y   <= y_nx;
      if (state == IDLE && start) mode_q <= mode;
    end
  end
  always_comb begin
    state_nx = state == IDLE  ? (start ? (shamt != '0 ? SHIFT : DONE) : IDLE) :
               state == SHIFT ? (rem == k ? DONE : SHIFT) : IDLE;
    rem_nx   = state == IDLE && start ? shamt : state == SHIFT ? rem - k : rem;
    y_nx     = state == IDLE && start ? a : state == SHIFT ? shifted : y;
  end
  always_comb begin
    busy = state == SHIFT;
    done = state == DONE;
  end
`ifdef SEQ_SHIFT_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) zero <= 1'b0;
    else if (state_nx == DONE) zero <= y_nx == '0;
  end
`endif
endmodule
